// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the external memory bus arbiter.
// Holds the FSM encoding, owner codes and the latched-request record.
package mem_bus_arbiter_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_DMA  = 1'b1;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr0;
    logic        wr1;
    logic        rd;
  } bus_req_t;

  // Any write lane wins over a read request.
  function automatic bus_req_t make_req(input logic [15:0] addr, input logic [15:0] wdata,
                                        input logic wr0, input logic wr1, input logic rd);
    bus_req_t r;
    r.addr  = addr;
    r.wdata = wdata;
    r.wr0   = wr0;
    r.wr1   = wr1;
    r.rd    = rd & ~(wr0 | wr1);
    return r;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the external memory bus: fixed wait-state access window,
// one-cycle ACK, core priority with a burst limit that protects the secondary master.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned CORE_BURST  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic [15:0] c_addr,
  input  logic [15:0] c_wdata,
  input  logic        c_wr0,
  input  logic        c_wr1,
  input  logic        c_rd,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic        d_wr0,
  input  logic        d_wr1,
  input  logic        d_rd,
  output logic        c_ack,
  output logic        d_ack,
  output logic [15:0] rdata,
  output logic [15:0] addr_buf,
  output logic [15:0] dout_buf,
  input  logic [15:0] din_buf,
  output logic        wr0_buf,
  output logic        wr1_buf,
  output logic        rd_buf,
  output logic        busy,
  output logic        owner
);

  localparam logic [CNT_W-1:0] WaitLoad  = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] BurstMax  = CNT_W'(CORE_BURST);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  bus_req_t         req_q, req_d;
  logic             owner_q, owner_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             grant_dma;

  assign grant_dma = d_req & (~c_req | (burst_q == BurstMax));

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    burst_d = burst_q;
    req_d   = req_q;
    owner_d = owner_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (c_req || d_req) begin
          state_d = ST_ACCESS;
          wait_d  = WaitLoad;
          if (grant_dma) begin
            owner_d = OWNER_DMA;
            req_d   = make_req(d_addr, d_wdata, d_wr0, d_wr1, d_rd);
            burst_d = '0;
          end else begin
            owner_d = OWNER_CORE;
            req_d   = make_req(c_addr, c_wdata, c_wr0, c_wr1, c_rd);
            if (!d_req) begin
              burst_d = '0;
            end else if (burst_q != BurstMax) begin
              burst_d = burst_q + 4'd1;
            end
          end
        end
      end
      ST_ACCESS: begin
        if (wait_q == '0) begin
          state_d = ST_DONE;
          if (req_q.rd) begin
            rdata_d = din_buf;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      burst_q <= '0;
      req_q   <= '0;
      owner_q <= OWNER_CORE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      burst_q <= burst_d;
      req_q   <= req_d;
      owner_q <= owner_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes are gated by the state register so an async reset drops them at once.
  assign wr0_buf  = (state_q == ST_ACCESS) & req_q.wr0;
  assign wr1_buf  = (state_q == ST_ACCESS) & req_q.wr1;
  assign rd_buf   = (state_q == ST_ACCESS) & req_q.rd;
  assign addr_buf = req_q.addr;
  assign dout_buf = req_q.wdata;
  assign rdata    = rdata_q;
  assign c_ack    = (state_q == ST_DONE) & (owner_q == OWNER_CORE);
  assign d_ack    = (state_q == ST_DONE) & (owner_q == OWNER_DMA);
  assign busy     = (state_q != ST_IDLE);
  assign owner    = owner_q;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single external memory bus (ADDR_BUF/DOUT_BUF/DIN_BUF/WR0_BUF/WR1_BUF/RD_BUF) between the CPU core and a secondary requester (DMA or debug port). It sequences each access through a fixed wait-state window and returns read data with a one-cycle acknowledge. It uses fixed priority with a starvation guard. It sits between `core` plus the secondary master and the board-level memory buffers.

## Interface
- WAIT_STATES, 1: extra bus cycles per access; legal range 0–15.
- CORE_BURST, 4: maximum consecutive core grants while the secondary requester is pending; legal range 1–15.
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- C_REQ, D_REQ  in  1  request from the core / secondary requester; held until ACK.
- C_ADDR, D_ADDR  in  16  byte address.
- C_WDATA, D_WDATA  in  16  write data; bits 15:8 are the high lane, bits 7:0 the low lane.
- C_WR0/C_WR1, D_WR0/D_WR1  in  1  low/high byte-lane write enables.
- C_RD, D_RD  in  1  read request.
- C_ACK, D_ACK  out  1  one-cycle completion pulse.
- RDATA  out  16  read data; valid in the ACK cycle.
- ADDR_BUF  out  16  bus address.
- DOUT_BUF  out  16  bus write data.
- DIN_BUF  in  16  bus read data.
- WR0_BUF, WR1_BUF, RD_BUF  out  1  bus strobes, active-high.
- BUSY  out  1  FSM is not in IDLE.
- OWNER  out  1  owner of the current or last access: 0 = core, 1 = secondary.

## Operation
- States:
  - IDLE
  - ACCESS: lasts WAIT_STATES+1 cycles.
  - DONE: lasts 1 cycle.
- IDLE:
  - If any REQ is high, select the winner, latch its ADDR, WDATA and strobes into registers, load the wait counter with WAIT_STATES, and go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - The core wins by default.
  - The secondary requester wins if only D_REQ is high, or if both are high and the burst counter equals CORE_BURST.
- Burst counter:
  - Increments on a core grant made while D_REQ is high.
  - Clears on a secondary grant, or when D_REQ is low at grant time.
  - Saturates at CORE_BURST.
- ACCESS:
  - Drive the latched ADDR_BUF, DOUT_BUF and strobes from registers.
  - Decrement the wait counter each cycle; go to DONE when it is 0.
  - Capture DIN_BUF into RDATA in the final ACCESS cycle.
- DONE:
  - All strobes are low; ADDR_BUF holds its value.
  - Pulse the owner's ACK.
  - Go to IDLE.
- Strobe rules:
  - If any WR lane is set, RD is ignored.
  - WR0 and WR1 both set means a 16-bit write.
  - A request with no strobes completes as a no-op: full sequence and ACK, bus strobes never asserted.
- RDATA holds its value until the next read completes; writes do not change it.
- Requester inputs are ignored after the latch; changes during ACCESS have no effect.

## Timing
- Reset values: state IDLE, all strobes 0, ADDR_BUF/DOUT_BUF/RDATA 0x0000, ACKs 0, BUSY 0, OWNER 0, counters 0.
- RESET asserted mid-access drops all strobes immediately (asynchronously). No ACK is issued for the aborted access.
- With REQ first sampled high in IDLE at edge t:
  - Strobes are high from t+1 through t+1+WAIT_STATES.
  - ACK is high in cycle t+2+WAIT_STATES.
  - FSM is back in IDLE at t+3+WAIT_STATES.
- A REQ still high in the first IDLE cycle after DONE is a new request. Requesters drop REQ on the edge that ends their ACK cycle.
- Peak throughput is one access per WAIT_STATES+3 cycles.
- Simultaneous requests in IDLE are resolved by the arbitration rule only; the losing REQ is served after the current DONE.
- Back-to-back transfers always leave at least one strobe-low cycle (DONE) between accesses.

## Structure
- Shared package constants:
  - state encodings ST_IDLE, ST_ACCESS, ST_DONE
  - OWNER_CORE = 0, OWNER_DMA = 1
- No sub-module. The FSM, wait counter, burst counter and the request latch mux live in one module.

## Test plan
- Core write: WAIT_STATES=1, C_REQ with addr 0x1001, data 0x3500, WR1 only. WR1_BUF is high for 2 cycles, WR0_BUF stays low, ADDR_BUF=0x1001, C_ACK pulses 3 cycles after REQ is sampled.
- Core read: DIN_BUF=0x3579 during the final ACCESS cycle. RDATA=0x3579 in the C_ACK cycle and is held afterwards.
- Starvation guard: C_REQ and D_REQ held continuously, CORE_BURST=4. Grant order is C,C,C,C,D,C,C,C,C,D.
- Simultaneous first request: both REQ rise together in IDLE. The core is served first, D_ACK follows WAIT_STATES+3 cycles after C_ACK, OWNER toggles 0→1.
- Mid-access reset: RESET asserted in the first ACCESS cycle of a write. Strobes are 0 in the same cycle, no ACK, BUSY=0, and the first request after reset release completes normally.
- No-op and WAIT_STATES=0: a REQ with no strobes gives an ACK 2 cycles after REQ with no strobe activity. A read with WAIT_STATES=0 has RD_BUF high for exactly 1 cycle.
